// File: rtl/mipi_tx_pkg.sv
// Shared encodings for the MIPI TX command arbiter: FSM states, bus owner, packet data types.
package mipi_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StVidCmd = 3'd1,
    StVidPay = 3'd2,
    StAuxCmd = 3'd3,
    StAuxPay = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnVid  = 2'd1,
    OwnAux  = 2'd2
  } owner_e;

  localparam logic [5:0] DT_VSYNC_START  = 6'h01;
  localparam logic [5:0] DT_DCS_SHORT_W0 = 6'h05;
  localparam logic [5:0] DT_NULL         = 6'h09;
  localparam logic [5:0] DT_DCS_SHORT_W1 = 6'h15;
  localparam logic [5:0] DT_BLANK        = 6'h19;
  localparam logic [5:0] DT_HSYNC_START  = 6'h21;
  localparam logic [5:0] DT_GEN_LONG     = 6'h29;
  localparam logic [5:0] DT_RGB666_LOOSE = 6'h2E;
  localparam logic [5:0] DT_DCS_LONG     = 6'h39;
  localparam logic [5:0] DT_RGB888       = 6'h3E;

  // Long packets carry a payload phase; identified by the low nibble of the data type.
  function automatic logic is_long_pkt(input logic [5:0] dt);
    logic long_pkt;
    case (dt[3:0])
      4'h9, 4'hC, 4'hD, 4'hE: long_pkt = 1'b1;
      default:                long_pkt = 1'b0;
    endcase
    return long_pkt;
  endfunction

endpackage

// File: rtl/mipi_tx_watchdog.sv
// Loadable down-counter; expire pulses on the last allowed cycle of the loaded window.
module mipi_tx_watchdog #(
  parameter int unsigned Width = 16
) (
  input  logic             CLK_tx,
  input  logic             RST,
  input  logic             load,
  input  logic [Width-1:0] limit,
  input  logic             en,
  output logic             expire
);

  logic [Width-1:0] count_q;

  always_ff @(posedge CLK_tx) begin
    if (RST) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= limit;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // count_q == 1 marks the limit-th cycle since the load.
  assign expire = en && (count_q == Width'(1));

endmodule

// File: rtl/mipi_tx_cmd_arbiter.sv
// Arbitrates the TX controller command/payload port between the video timing generator (VID,
// absolute priority) and an auxiliary command source (AUX, vertical blanking only, capped).
module mipi_tx_cmd_arbiter
  import mipi_tx_pkg::*;
#(
  parameter logic [15:0] ACK_TIMEOUT        = 16'd4096,
  parameter logic [15:0] PAY_TIMEOUT        = 16'd8192,
  parameter logic [3:0]  AUX_MAX_PER_VBLANK = 4'd8
) (
  input  logic        CLK_tx,
  input  logic        RST,
  input  logic        Vblank,
  input  logic        Vid_cmd_req,
  input  logic [5:0]  Vid_cmd_data_type,
  input  logic [15:0] Vid_cmd_byte_count,
  output logic        Vid_cmd_ack,
  output logic        Vid_payload_en,
  output logic        Vid_payload_en_last,
  input  logic        Aux_cmd_req,
  input  logic [5:0]  Aux_cmd_data_type,
  input  logic [15:0] Aux_cmd_byte_count,
  output logic        Aux_cmd_ack,
  output logic        Aux_payload_en,
  output logic        Aux_payload_en_last,
  output logic        Tx_cmd_req,
  output logic [5:0]  Tx_cmd_data_type,
  output logic [15:0] Tx_cmd_byte_count,
  input  logic        Tx_cmd_ack,
  input  logic        Tx_payload_en,
  input  logic        Tx_payload_en_last,
  output logic [1:0]  Owner,
  output logic        Err_timeout
);

  state_e      state_q, state_d;
  owner_e      owner;
  logic [5:0]  dt_q;
  logic [15:0] bc_q;
  logic        tx_req_q;
  logic        err_q;
  logic [3:0]  aux_cnt_q, aux_cnt_d;
  logic        aux_ok;
  logic        timeout;
  logic        grant;
  logic        wd_load;
  logic        wd_en;
  logic        wd_expire;
  logic [15:0] wd_limit;

  assign aux_ok = Vblank && (aux_cnt_q < AUX_MAX_PER_VBLANK);

  always_ff @(posedge CLK_tx) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // An ack or last strobe in the expiring cycle still completes the packet normally.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Vid_cmd_req) begin
          state_d = StVidCmd;
        end else if (Aux_cmd_req && aux_ok) begin
          state_d = StAuxCmd;
        end
      end
      StVidCmd: begin
        if (Tx_cmd_ack) begin
          state_d = is_long_pkt(dt_q) ? StVidPay : StIdle;
        end else if (wd_expire) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      StVidPay: begin
        if (Tx_payload_en_last) begin
          state_d = StIdle;
        end else if (wd_expire) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      StAuxCmd: begin
        if (Tx_cmd_ack) begin
          state_d = is_long_pkt(dt_q) ? StAuxPay : StIdle;
        end else if (wd_expire) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      StAuxPay: begin
        if (Tx_payload_en_last) begin
          state_d = StIdle;
        end else if (wd_expire) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant   = (state_q == StIdle) && (state_d != StIdle);
  assign wd_en   = (state_q != StIdle);
  assign wd_load = (state_d != state_q);

  always_comb begin
    wd_limit = '0;
    unique case (state_d)
      StVidCmd, StAuxCmd: wd_limit = ACK_TIMEOUT;
      StVidPay, StAuxPay: wd_limit = PAY_TIMEOUT;
      default:            wd_limit = '0;
    endcase
  end

  mipi_tx_watchdog #(
    .Width (16)
  ) u_watchdog (
    .CLK_tx (CLK_tx),
    .RST    (RST),
    .load   (wd_load),
    .limit  (wd_limit),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Held at zero while Vblank is low, so every Vblank rise starts a fresh window.
  always_comb begin
    aux_cnt_d = aux_cnt_q;
    if (!Vblank) begin
      aux_cnt_d = '0;
    end else if ((state_q == StAuxCmd) && Tx_cmd_ack) begin
      aux_cnt_d = aux_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK_tx) begin
    if (RST) begin
      tx_req_q  <= 1'b0;
      err_q     <= 1'b0;
      aux_cnt_q <= '0;
      dt_q      <= '0;
      bc_q      <= '0;
    end else begin
      tx_req_q  <= (state_d == StVidCmd) || (state_d == StAuxCmd);
      err_q     <= timeout;
      aux_cnt_q <= aux_cnt_d;
      if (grant) begin
        if (state_d == StVidCmd) begin
          dt_q <= Vid_cmd_data_type;
          bc_q <= Vid_cmd_byte_count;
        end else begin
          dt_q <= Aux_cmd_data_type;
          bc_q <= Aux_cmd_byte_count;
        end
      end
    end
  end

  always_comb begin
    owner = OwnNone;
    unique case (state_q)
      StVidCmd, StVidPay: owner = OwnVid;
      StAuxCmd, StAuxPay: owner = OwnAux;
      default:            owner = OwnNone;
    endcase
  end

  // Forwarding is gated by RST so an in-flight packet is cut off in the reset cycle itself.
  always_comb begin
    Vid_cmd_ack         = !RST && (owner == OwnVid) && Tx_cmd_ack;
    Vid_payload_en      = !RST && (owner == OwnVid) && Tx_payload_en;
    Vid_payload_en_last = !RST && (owner == OwnVid) && Tx_payload_en_last;
    Aux_cmd_ack         = !RST && (owner == OwnAux) && Tx_cmd_ack;
    Aux_payload_en      = !RST && (owner == OwnAux) && Tx_payload_en;
    Aux_payload_en_last = !RST && (owner == OwnAux) && Tx_payload_en_last;
    Tx_cmd_req          = tx_req_q;
    Tx_cmd_data_type    = dt_q;
    Tx_cmd_byte_count   = bc_q;
    Owner               = owner;
    Err_timeout         = err_q;
  end

endmodule
